// File: rtl/cordic_result_fifo.sv
// First-word-fall-through result buffer between the CORDIC core and its AHB-Lite slave.
// Define CORDIC_FIFO_POP_EDGE_EN to pop once per rising edge of read_fifo_en instead of once per cycle.
module cordic_result_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic [DATA_WIDTH-1:0] out_interface,
   input  logic                  valid_out_interface,
   input  logic                  read_fifo_en,
   input  logic                  flush,
   input  logic                  clr_flags,
   output logic [DATA_WIDTH-1:0] out_fifo,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  rd_req;
   logic                  push;
   logic                  pop;
   logic                  overflow_set;
   logic                  underflow_set;

`ifdef CORDIC_FIFO_POP_EDGE_EN
   logic rd_en_q;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) rd_en_q <= 1'b0;
      else        rd_en_q <= read_fifo_en;
   end

   assign rd_req = read_fifo_en && !rd_en_q;
`else
   assign rd_req = read_fifo_en;
`endif

   // Flags come straight off the count register so read_fifo_en never reaches them.
   assign empty = (count == '0);
   assign full  = (count == FULL_COUNT);

   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign pop           = rd_req && !empty;
   assign push          = valid_out_interface && (!full || pop);
   assign overflow_set  = valid_out_interface && full && !pop;
   assign underflow_set = rd_req && empty;

   // NOTE: the storage array has no reset; validity lives entirely in the pointers and count.
   always_ff @(posedge HCLK) begin
      if (push && !flush) mem[wr_ptr] <= out_interface;
   end

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         unique case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // A set event in the same cycle as clr_flags wins.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (overflow_set)   overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;
         if (underflow_set)   underflow <= 1'b1;
         else if (clr_flags)  underflow <= 1'b0;
      end
   end

   // NOTE: combinational outputs get a default first so no latch is inferred.
   always_comb begin
      out_fifo = '0;
      if (!empty) out_fifo = mem[rd_ptr];
   end

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Directed self-checking bench for cordic_result_fifo with hand-computed expectations.
// Expected pop count in the level-held read test follows CORDIC_FIFO_POP_EDGE_EN.
module tb_cordic_result_fifo;

   localparam int DW = 32;
   localparam int DL = 4;

   logic          HCLK = 1'b0;
   logic          HRESET;
   logic [DW-1:0] out_interface;
   logic          valid_out_interface;
   logic          read_fifo_en;
   logic          flush;
   logic          clr_flags;
   logic [DW-1:0] out_fifo;
   logic          empty;
   logic          full;
   logic [DL:0]   count;
   logic          overflow;
   logic          underflow;

   int tests_run = 0;
   int tests_failed = 0;

   cordic_result_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
      .HCLK                (HCLK),
      .HRESET              (HRESET),
      .out_interface       (out_interface),
      .valid_out_interface (valid_out_interface),
      .read_fifo_en        (read_fifo_en),
      .flush               (flush),
      .clr_flags           (clr_flags),
      .out_fifo            (out_fifo),
      .empty               (empty),
      .full                (full),
      .count               (count),
      .overflow            (overflow),
      .underflow           (underflow)
   );

   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge and outputs are sampled there too.
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      valid_out_interface = 1'b1;
      out_interface       = d;
      step();
      valid_out_interface = 1'b0;
   endtask

   // One-cycle pulse followed by an idle cycle so both pop modes see a fresh request.
   task automatic pop_one();
      read_fifo_en = 1'b1;
      step();
      read_fifo_en = 1'b0;
      step();
   endtask

   logic [DW-1:0] exp_q [$];
   int            exp_pop_count;

   initial begin
      HRESET              = 1'b1;
      out_interface       = '0;
      valid_out_interface = 1'b0;
      read_fifo_en        = 1'b0;
      flush               = 1'b0;
      clr_flags           = 1'b0;
      step();

      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full", 64'(full), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_unf", 64'(underflow), 64'd0);
      check("rst_out", 64'(out_fifo), 64'd0);
      HRESET = 1'b0;
      step();

      // Three back-to-back pushes, then single pops.
      push_word(32'h11);
      check("fwft_first_out", 64'(out_fifo), 64'h11);
      check("fwft_first_empty", 64'(empty), 64'd0);
      push_word(32'h22);
      push_word(32'h33);
      check("three_count", 64'(count), 64'd3);
      pop_one();
      check("pop1_out", 64'(out_fifo), 64'h22);
      pop_one();
      check("pop2_out", 64'(out_fifo), 64'h33);
      pop_one();
      check("pop3_empty", 64'(empty), 64'd1);
      check("pop3_out", 64'(out_fifo), 64'd0);
      check("pop3_count", 64'(count), 64'd0);

      // Fill, then overflow with 0xDEAD.
      for (int i = 0; i < 16; i++) push_word(DW'(i));
      check("fill_full", 64'(full), 64'd1);
      check("fill_count", 64'(count), 64'd16);
      check("fill_no_ovf", 64'(overflow), 64'd0);
      push_word(32'hDEAD);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_count", 64'(count), 64'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("drain_%0d", i), 64'(out_fifo), 64'(i));
         pop_one();
      end
      check("drain_empty", 64'(empty), 64'd1);
      check("drain_ovf_sticky", 64'(overflow), 64'd1);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("clr_ovf", 64'(overflow), 64'd0);

      // Full with simultaneous push and pop.
      for (int i = 0; i < 16; i++) push_word(DW'(32'h100 + i));
      valid_out_interface = 1'b1;
      out_interface       = 32'hBEEF;
      read_fifo_en        = 1'b1;
      step();
      valid_out_interface = 1'b0;
      read_fifo_en        = 1'b0;
      step();
      check("fullrw_count", 64'(count), 64'd16);
      check("fullrw_full", 64'(full), 64'd1);
      check("fullrw_no_ovf", 64'(overflow), 64'd0);
      exp_q.delete();
      for (int i = 1; i < 16; i++) exp_q.push_back(DW'(32'h100 + i));
      exp_q.push_back(32'hBEEF);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("wrap_%0d", i), 64'(out_fifo), 64'(exp_q[i]));
         pop_one();
      end
      check("wrap_empty", 64'(empty), 64'd1);

      // Empty with simultaneous push and pop.
      valid_out_interface = 1'b1;
      out_interface       = 32'h55;
      read_fifo_en        = 1'b1;
      step();
      valid_out_interface = 1'b0;
      read_fifo_en        = 1'b0;
      check("emptyrw_count", 64'(count), 64'd1);
      check("emptyrw_out", 64'(out_fifo), 64'h55);
      check("emptyrw_unf", 64'(underflow), 64'd1);

      // Flush at count 5 with push and pop; flags must hold.
      for (int i = 0; i < 4; i++) push_word(DW'(32'h60 + i));
      check("preflush_count", 64'(count), 64'd5);
      flush               = 1'b1;
      valid_out_interface = 1'b1;
      out_interface       = 32'h77;
      read_fifo_en        = 1'b1;
      step();
      flush               = 1'b0;
      valid_out_interface = 1'b0;
      read_fifo_en        = 1'b0;
      check("flush_count", 64'(count), 64'd0);
      check("flush_empty", 64'(empty), 64'd1);
      check("flush_out", 64'(out_fifo), 64'd0);
      check("flush_unf_kept", 64'(underflow), 64'd1);
      check("flush_ovf_kept", 64'(overflow), 64'd0);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("clr_unf", 64'(underflow), 64'd0);

      // Level-held read for three cycles with four words stored.
      for (int i = 0; i < 4; i++) push_word(DW'(32'hA0 + i));
      read_fifo_en = 1'b1;
      step();
      step();
      step();
      read_fifo_en = 1'b0;
`ifdef CORDIC_FIFO_POP_EDGE_EN
      exp_pop_count = 1;
`else
      exp_pop_count = 3;
`endif
      check("held_rd_count", 64'(count), 64'(4 - exp_pop_count));
      check("held_rd_out", 64'(out_fifo), 64'(32'hA0 + exp_pop_count));

      // Asynchronous reset in the middle of a push burst.
      valid_out_interface = 1'b1;
      out_interface       = 32'hC0;
      step();
      out_interface = 32'hC1;
      #2;
      HRESET = 1'b1;
      #1;
      check("async_rst_count", 64'(count), 64'd0);
      check("async_rst_empty", 64'(empty), 64'd1);
      check("async_rst_out", 64'(out_fifo), 64'd0);
      check("async_rst_full", 64'(full), 64'd0);
      valid_out_interface = 1'b0;
      step();
      HRESET = 1'b0;
      step();
      push_word(32'hE1);
      check("post_rst_out", 64'(out_fifo), 64'hE1);
      check("post_rst_count", 64'(count), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
